// File: rtl/sp_ram_arb_pkg.sv
// rtl/sp_ram_arb_pkg.sv - shared types and constants for the two-port RAM arbiter
package sp_ram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

  // One outstanding response: which port it belongs to and whether it faulted
  typedef struct packed {
    logic      valid;
    port_sel_t port;
    logic      err;
  } resp_t;

endpackage

// File: rtl/sp_ram_arb2_rr_arb2.sv
// rtl/sp_ram_arb2_rr_arb2.sv - two-input round-robin arbiter with pointer register
module rr_arb2
  import sp_ram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  port_sel_t ptr_q;
  port_sel_t ptr_d;

  // Grant is combinational; the pointer only breaks ties, and reset masks everything
  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (ptr_q == PORT_A) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // After a contended cycle the loser gets priority next time
  always_comb begin
    ptr_d = ptr_q;
    if (req_i == 2'b11) begin
      ptr_d = (ptr_q == PORT_A) ? PORT_B : PORT_A;
    end
  end

  // Pointer register
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ptr_q <= PORT_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sp_ram_arb2.sv
// rtl/sp_ram_arb2.sv - two-master req/gnt/rvalid arbiter in front of a single-port RAM (optional SP_RAM_ARB_RDATA_HOLD_EN)
module sp_ram_arb2
  import sp_ram_arb_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_i,

  input  logic                    a_req_i,
  output logic                    a_gnt_o,
  input  logic [31:0]             a_addr_i,
  input  logic                    a_we_i,
  input  logic [DATA_WIDTH/8-1:0] a_be_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic                    a_rvalid_o,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_err_o,

  input  logic                    b_req_i,
  output logic                    b_gnt_o,
  input  logic [31:0]             b_addr_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic                    b_rvalid_o,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_err_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);

  logic [NUM_PORTS-1:0] gnt;
  logic                 a_in_range;
  logic                 b_in_range;
  logic                 use_b;
  logic [DATA_WIDTH-1:0] rdata_live;
  resp_t                resp_q;
  resp_t                resp_d;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_i (rst_i),
    .req_i ({b_req_i, a_req_i}),
    .gnt_o (gnt)
  );

  assign a_gnt_o    = gnt[0];
  assign b_gnt_o    = gnt[1];
  assign a_in_range = (a_addr_i < RAM_LIMIT);
  assign b_in_range = (b_addr_i < RAM_LIMIT);

  // Port B drives the RAM bus only when it actually reaches the RAM; otherwise A's values sit there
  assign use_b       = gnt[1] & b_in_range;
  assign ram_en_o    = (gnt[0] & a_in_range) | use_b;
  assign ram_addr_o  = use_b ? b_addr_i[ADDR_WIDTH-1:0] : a_addr_i[ADDR_WIDTH-1:0];
  assign ram_wdata_o = use_b ? b_wdata_i : a_wdata_i;
  assign ram_be_o    = use_b ? b_be_i : a_be_i;
  assign ram_we_o    = ram_en_o & (use_b ? b_we_i : a_we_i);

  // Record who was granted this cycle so the next cycle's RAM data is steered back
  always_comb begin
    resp_d       = '0;
    resp_d.valid = |gnt;
    resp_d.port  = gnt[1] ? PORT_B : PORT_A;
    resp_d.err   = (gnt[0] & ~a_in_range) | (gnt[1] & ~b_in_range);
  end

  // Response register; a reset in the response cycle drops it
  always_ff @(posedge clk) begin
    if (rst_i) begin
      resp_q <= '{valid: 1'b0, port: PORT_A, err: 1'b0};
    end else begin
      resp_q <= resp_d;
    end
  end

  assign a_rvalid_o = resp_q.valid & (resp_q.port == PORT_A) & ~rst_i;
  assign b_rvalid_o = resp_q.valid & (resp_q.port == PORT_B) & ~rst_i;
  assign a_err_o    = a_rvalid_o & resp_q.err;
  assign b_err_o    = b_rvalid_o & resp_q.err;
  assign rdata_live = resp_q.err ? '0 : ram_rdata_i;

`ifdef SP_RAM_ARB_RDATA_HOLD_EN
  logic [DATA_WIDTH-1:0] a_hold_q;
  logic [DATA_WIDTH-1:0] b_hold_q;

  // Keep each port's last response visible until its next one
  always_ff @(posedge clk) begin
    if (rst_i) begin
      a_hold_q <= '0;
      b_hold_q <= '0;
    end else begin
      if (a_rvalid_o) a_hold_q <= rdata_live;
      if (b_rvalid_o) b_hold_q <= rdata_live;
    end
  end

  assign a_rdata_o = a_rvalid_o ? rdata_live : a_hold_q;
  assign b_rdata_o = b_rvalid_o ? rdata_live : b_hold_q;
`else
  assign a_rdata_o = a_rvalid_o ? rdata_live : '0;
  assign b_rdata_o = b_rvalid_o ? rdata_live : '0;
`endif

endmodule

// File: tb/tb_sp_ram_arb2.sv
// tb/tb_sp_ram_arb2.sv - scoreboard bench for sp_ram_arb2 with a behavioural RAM and reference model
module tb_sp_ram_arb2;

  localparam int RAM_SIZE = 32768;

  logic        clk;
  logic        rst_i;
  logic        a_req_i, b_req_i, a_gnt_o, b_gnt_o;
  logic [31:0] a_addr_i, b_addr_i, a_wdata_i, b_wdata_i;
  logic        a_we_i, b_we_i;
  logic [3:0]  a_be_i, b_be_i;
  logic        a_rvalid_o, b_rvalid_o, a_err_o, b_err_o;
  logic [31:0] a_rdata_o, b_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [14:0] ram_addr_o;
  logic [31:0] ram_wdata_o, ram_rdata_i;
  logic [3:0]  ram_be_o;

  sp_ram_arb2 dut (
    .clk(clk), .rst_i(rst_i),
    .a_req_i(a_req_i), .a_gnt_o(a_gnt_o), .a_addr_i(a_addr_i), .a_we_i(a_we_i),
    .a_be_i(a_be_i), .a_wdata_i(a_wdata_i), .a_rvalid_o(a_rvalid_o),
    .a_rdata_o(a_rdata_o), .a_err_o(a_err_o),
    .b_req_i(b_req_i), .b_gnt_o(b_gnt_o), .b_addr_i(b_addr_i), .b_we_i(b_we_i),
    .b_be_i(b_be_i), .b_wdata_i(b_wdata_i), .b_rvalid_o(b_rvalid_o),
    .b_rdata_o(b_rdata_o), .b_err_o(b_err_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
    .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  typedef struct {
    int          due;
    bit          port;
    bit          err;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t        q[$];
  bit [31:0]   ref_mem[int];
  bit          mptr;
  int          cyc;
  int          n_checks;
  int          n_pass;
  logic [31:0] hold_m[2];
  bit          hold_k[2];

  // Environment RAM: one-cycle read latency, byte-enabled writes
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    if (ram_en_o) begin
      ram_rdata_i <= mem[ram_addr_o[14:2]];
      if (ram_we_o)
        for (int k = 0; k < 4; k++)
          if (ram_be_o[k]) mem[ram_addr_o[14:2]][8*k +: 8] <= ram_wdata_o[8*k +: 8];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic bit [31:0] ref_read(input logic [31:0] addr);
    int idx = int'(addr >> 2);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  // One bus cycle: drive both masters, predict grant and RAM access, queue the expected response
  task automatic step(input txn_t a, input txn_t b, input bit rst, output bit ga, output bit gb);
    txn_t w;
    bit   inr;
    int   idx;
    @(posedge clk);
    #1;
    rst_i = rst;
    a_req_i = a.req; a_addr_i = a.addr; a_we_i = a.we; a_be_i = a.be; a_wdata_i = a.wd;
    b_req_i = b.req; b_addr_i = b.addr; b_we_i = b.we; b_be_i = b.be; b_wdata_i = b.wd;
    ga = 1'b0;
    gb = 1'b0;
    if (rst) begin
      q.delete();
      mptr = 1'b0;
      #1;
      check("rst_a_gnt", a_gnt_o, 0);
      check("rst_b_gnt", b_gnt_o, 0);
      check("rst_ram_en", ram_en_o, 0);
      return;
    end
    ga = a.req && (!b.req || mptr == 1'b0);
    gb = b.req && (!a.req || mptr == 1'b1);
    if (a.req && b.req) mptr = ga ? 1'b1 : 1'b0;
    #1;
    check("a_gnt", a_gnt_o, ga);
    check("b_gnt", b_gnt_o, gb);
    if (ga || gb) begin
      w   = gb ? b : a;
      inr = (w.addr < RAM_SIZE);
      check("ram_en", ram_en_o, inr);
      if (inr) begin
        check("ram_addr", ram_addr_o, w.addr[14:0]);
        check("ram_we", ram_we_o, w.we);
        check("ram_be", ram_be_o, w.be);
        if (w.we) check("ram_wdata", ram_wdata_o, w.wd);
      end else begin
        check("ram_we_oor", ram_we_o, 0);
      end
      q.push_back('{due: cyc + 1, port: gb, err: !inr,
                    data: inr ? ref_read(w.addr) : 32'h0, chk: !(inr && w.we)});
      if (inr && w.we) begin
        idx = int'(w.addr >> 2);
        if (!ref_mem.exists(idx)) ref_mem[idx] = 32'h0;
        for (int k = 0; k < 4; k++)
          if (w.be[k]) ref_mem[idx][8*k +: 8] = w.wd[8*k +: 8];
      end
    end else begin
      check("ram_en_idle", ram_en_o, 0);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response is due and compares both ports
  always @(negedge clk) begin
    if (rst_i) begin
      check("rst_a_rvalid", a_rvalid_o, 0);
      check("rst_b_rvalid", b_rvalid_o, 0);
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
      hold_m[0] = 0; hold_m[1] = 0; hold_k[0] = 1; hold_k[1] = 1;
`else
      check("rst_a_rdata", a_rdata_o, 0);
      check("rst_b_rdata", b_rdata_o, 0);
`endif
    end else begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("resp_late", q[0].due, cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("a_rvalid", a_rvalid_o, e.port == 1'b0);
        check("b_rvalid", b_rvalid_o, e.port == 1'b1);
        check("resp_err", e.port ? b_err_o : a_err_o, e.err);
        if (e.chk) check("resp_rdata", e.port ? b_rdata_o : a_rdata_o, e.data);
        hold_m[e.port] = e.data;
        hold_k[e.port] = e.chk;
      end else begin
        check("idle_a_rvalid", a_rvalid_o, 0);
        check("idle_b_rvalid", b_rvalid_o, 0);
`ifdef SP_RAM_ARB_RDATA_HOLD_EN
        if (hold_k[0]) check("a_rdata_hold", a_rdata_o, hold_m[0]);
        if (hold_k[1]) check("b_rdata_hold", b_rdata_o, hold_m[1]);
`else
        check("idle_a_rdata", a_rdata_o, 0);
        check("idle_b_rdata", b_rdata_o, 0);
`endif
      end
    end
  end

  function automatic txn_t mk(input logic [31:0] addr, input logic we, input logic [3:0] be,
                              input logic [31:0] wd);
    txn_t t;
    t.req = 1'b1; t.addr = addr; t.we = we; t.be = be; t.wd = wd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int   r;
    txn_t t;
    r = $urandom_range(0, 9);
    if (r == 0)      t.addr = 32'h8000 + 32'(4 * $urandom_range(0, 7));
    else if (r == 1) t.addr = 32'hFFFF_FFFC;
    else             t.addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
    t.req = 1'b1;
    t.we  = 1'($urandom_range(0, 1));
    t.be  = 4'($urandom_range(0, 15));
    t.wd  = $urandom;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    txn_t idle, pa, pb;
    bit   ga, gb;
    idle = '{req: 1'b0, addr: 32'h0, we: 1'b0, be: 4'h0, wd: 32'h0};
    n_checks = 0; n_pass = 0; cyc = 0; mptr = 1'b0;
    hold_m[0] = 0; hold_m[1] = 0; hold_k[0] = 1; hold_k[1] = 1;
    rst_i = 1'b1; ram_rdata_i = 32'h0;
    a_req_i = 0; a_addr_i = 0; a_we_i = 0; a_be_i = 0; a_wdata_i = 0;
    b_req_i = 0; b_addr_i = 0; b_we_i = 0; b_be_i = 0; b_wdata_i = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    mem[4]  = 32'hDEADBEEF;  ref_mem[4]  = 32'hDEADBEEF;
    mem[12] = 32'hCAFEF00D;  ref_mem[12] = 32'hCAFEF00D;

    step(idle, idle, 1'b1, ga, gb);
    step(idle, idle, 1'b1, ga, gb);

    // Single read of preloaded word
    step(mk(32'h10, 0, 4'hF, 0), idle, 1'b0, ga, gb);
    step(idle, idle, 1'b0, ga, gb);

    // Contention: A,B,A,B,A leaves priority with B
    for (int i = 0; i < 5; i++)
      step(mk(32'h10, 0, 4'hF, 0), mk(32'h30, 0, 4'hF, 0), 1'b0, ga, gb);

    // Byte write, out-of-range write aliasing the same low bits, then read back
    step(mk(32'h20, 1, 4'b0010, 32'h11223344), idle, 1'b0, ga, gb);
    step(idle, mk(32'h8020, 1, 4'hF, 32'hFFFFFFFF), 1'b0, ga, gb);
    step(mk(32'h20, 0, 4'hF, 0), idle, 1'b0, ga, gb);
    step(idle, mk(32'h8000, 0, 4'hF, 0), 1'b0, ga, gb);
    step(idle, idle, 1'b0, ga, gb);

    // A read then three B accesses (rdata hold on A)
    step(mk(32'h30, 0, 4'hF, 0), idle, 1'b0, ga, gb);
    step(idle, mk(32'h10, 0, 4'hF, 0), 1'b0, ga, gb);
    step(idle, mk(32'h20, 0, 4'hF, 0), 1'b0, ga, gb);
    step(idle, mk(32'h40, 1, 4'hF, 32'h5A5A5A5A), 1'b0, ga, gb);
    step(idle, idle, 1'b0, ga, gb);

    // Reset right after a grant: response dropped, pointer back to A
    step(idle, mk(32'h10, 0, 4'hF, 0), 1'b0, ga, gb);
    step(mk(32'h10, 0, 4'hF, 0), mk(32'h30, 0, 4'hF, 0), 1'b0, ga, gb);
    step(mk(32'h10, 0, 4'hF, 0), idle, 1'b0, ga, gb);
    step(idle, idle, 1'b1, ga, gb);
    step(idle, idle, 1'b0, ga, gb);
    step(mk(32'h10, 0, 4'hF, 0), mk(32'h30, 0, 4'hF, 0), 1'b0, ga, gb);
    check("ptr_after_reset", {gb, ga}, 2'b01);

    // Random traffic, each master holds its request until granted
    pa = idle; pb = idle;
    for (int i = 0; i < 400; i++) begin
      if (!pa.req && $urandom_range(0, 99) < 55) pa = rand_txn();
      if (!pb.req && $urandom_range(0, 99) < 55) pb = rand_txn();
      step(pa, pb, 1'b0, ga, gb);
      if (ga) pa.req = 1'b0;
      if (gb) pb.req = 1'b0;
    end

    for (int i = 0; i < 3; i++) step(idle, idle, 1'b0, ga, gb);
    check("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
